// File: rtl/cpu_pkg.sv
// Shared sizing and next-PC select encoding for the program-counter stage.
// Combinational definitions only: no latency, no backpressure.
package cpu_pkg;

    localparam int PC_W        = 10;
    localparam int STACK_DEPTH = 8;
    localparam int SP_W        = $clog2(STACK_DEPTH) + 1;

    typedef enum logic [1:0] {
        PC_HOLD,
        PC_INC,
        PC_JUMP,
        PC_RET
    } pc_sel_e;

endpackage

// File: rtl/ret_stack.sv
// Return-address LIFO: write at sp, combinational read at sp-1, error strobes for misuse.
// Latency: sp/contents update on the enabled edge; the read port is combinational.
// Backpressure: none; pushes when full and pops when empty are dropped and strobed.
module ret_stack
    import cpu_pkg::*;
#(
    parameter int W     = cpu_pkg::PC_W,
    parameter int DEPTH = cpu_pkg::STACK_DEPTH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   en,
    input  logic                   push,
    input  logic                   pop,
    input  logic [W-1:0]           wr_dat,
    output logic [W-1:0]           rd_dat,
    output logic [$clog2(DEPTH):0] sp,
    output logic                   empty,
    output logic                   full,
    output logic                   ovf_stb,
    output logic                   unf_stb,
    output logic                   cnf_stb
);

    localparam int IDX_W  = $clog2(DEPTH);
    localparam int SPW    = IDX_W + 1;

    logic [W-1:0]     mem_q [DEPTH];
    logic [SPW-1:0]   sp_q;
    logic [SPW-1:0]   sp_d;
    logic [IDX_W-1:0] wr_idx;
    logic [IDX_W-1:0] rd_idx;
    logic             push_ok;
    logic             pop_ok;

    always_comb begin
        empty   = (sp_q == '0);
        full    = (sp_q == SPW'(DEPTH));
        wr_idx  = sp_q[IDX_W-1:0];
        rd_idx  = sp_q[IDX_W-1:0] - 1'b1;
        // A simultaneous push and pop is an error and leaves the stack untouched.
        cnf_stb = en & push & pop;
        push_ok = en & push & ~pop & ~full;
        pop_ok  = en & pop & ~push & ~empty;
        ovf_stb = en & push & ~pop & full;
        unf_stb = en & pop & ~push & empty;
        sp_d    = sp_q;
        if (push_ok) begin
            sp_d = sp_q + 1'b1;
        end else if (pop_ok) begin
            sp_d = sp_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sp_q <= '0;
        end else begin
            sp_q <= sp_d;
        end
    end

    // Contents are deliberately not cleared by reset; only sp is.
    always_ff @(posedge clk) begin
        if (!reset && push_ok) begin
            mem_q[wr_idx] <= wr_dat;
        end
    end

    assign rd_dat = mem_q[rd_idx];
    assign sp     = sp_q;

endmodule

// File: rtl/pc_stack.sv
// PC register with next-PC priority mux, return-address stack and sticky error flags.
// Latency: pc/sp/flags update one edge after controls are sampled; en=0 stalls everything.
// Backpressure: none; misuse of the stack is recorded in sticky flags, never stalls.
module pc_stack
    import cpu_pkg::*;
#(
    parameter int PC_W  = cpu_pkg::PC_W,
    parameter int DEPTH = cpu_pkg::STACK_DEPTH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   en,
    input  logic                   s_inc,
    input  logic                   push,
    input  logic                   pop,
    input  logic [PC_W-1:0]        jump_addr,
    output logic [PC_W-1:0]        pc,
    output logic [$clog2(DEPTH):0] sp,
    output logic                   stack_empty,
    output logic                   stack_full,
    output logic                   overflow,
    output logic                   underflow,
    output logic                   conflict
);

    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] pc_d;
    logic [PC_W-1:0] pc_inc;
    logic [PC_W-1:0] ret_dat;
    logic            overflow_q;
    logic            overflow_d;
    logic            underflow_q;
    logic            underflow_d;
    logic            conflict_q;
    logic            conflict_d;
    logic            stk_empty;
    logic            stk_full;
    logic            ovf_stb;
    logic            unf_stb;
    logic            cnf_stb;
    pc_sel_e         sel;

    ret_stack #(
        .W     (PC_W),
        .DEPTH (DEPTH)
    ) u_ret_stack (
        .clk     (clk),
        .reset   (reset),
        .en      (en),
        .push    (push),
        .pop     (pop),
        .wr_dat  (pc_inc),
        .rd_dat  (ret_dat),
        .sp      (sp),
        .empty   (stk_empty),
        .full    (stk_full),
        .ovf_stb (ovf_stb),
        .unf_stb (unf_stb),
        .cnf_stb (cnf_stb)
    );

    always_comb begin
        pc_inc = pc_q + 1'b1;
        sel    = PC_HOLD;
        if (en) begin
            if (push && pop) begin
                sel = PC_INC;
            end else if (pop) begin
                sel = stk_empty ? PC_INC : PC_RET;
            end else if (push) begin
                // A CALL still jumps when the stack is full; only the return address is lost.
                sel = PC_JUMP;
            end else begin
                sel = s_inc ? PC_INC : PC_JUMP;
            end
        end

        pc_d = pc_q;
        case (sel)
            PC_INC:  pc_d = pc_inc;
            PC_JUMP: pc_d = jump_addr;
            PC_RET:  pc_d = ret_dat;
            default: pc_d = pc_q;
        endcase

        overflow_d  = overflow_q  | ovf_stb;
        underflow_d = underflow_q | unf_stb;
        conflict_d  = conflict_q  | cnf_stb;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q        <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            conflict_q  <= 1'b0;
        end else begin
            pc_q        <= pc_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
            conflict_q  <= conflict_d;
        end
    end

    assign pc          = pc_q;
    assign stack_empty = stk_empty;
    assign stack_full  = stk_full;
    assign overflow    = overflow_q;
    assign underflow   = underflow_q;
    assign conflict    = conflict_q;

endmodule

// File: tb/tb_pc_stack.sv
// Randomised and directed bench for pc_stack against a queue-based reference model.
module tb_pc_stack;

    localparam int PC_W  = 10;
    localparam int DEPTH = 8;

    logic            clk = 1'b0;
    logic            reset, en, s_inc, push, pop;
    logic [PC_W-1:0] jump_addr;
    logic [PC_W-1:0] pc;
    logic [3:0]      sp;
    logic            stack_empty, stack_full, overflow, underflow, conflict;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [PC_W-1:0] pc_m;
    logic [PC_W-1:0] stk_m[$];
    logic            ovf_m, unf_m, cnf_m;

    pc_stack #(.PC_W(PC_W), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .en          (en),
        .s_inc       (s_inc),
        .push        (push),
        .pop         (pop),
        .jump_addr   (jump_addr),
        .pc          (pc),
        .sp          (sp),
        .stack_empty (stack_empty),
        .stack_full  (stack_full),
        .overflow    (overflow),
        .underflow   (underflow),
        .conflict    (conflict)
    );

    always #5 clk = ~clk;

    // Apply one cycle of controls, advance past the edge, update the model.
    task automatic step(input logic r, input logic e, input logic si, input logic pu,
                        input logic po, input logic [PC_W-1:0] ja);
        logic [PC_W-1:0] nxt;
        reset = r; en = e; s_inc = si; push = pu; pop = po; jump_addr = ja;
        @(posedge clk);
        #1;
        nxt = pc_m + 1'b1;
        if (r) begin
            pc_m = '0;
            stk_m.delete();
            ovf_m = 1'b0; unf_m = 1'b0; cnf_m = 1'b0;
        end else if (e) begin
            if (pu && po) begin
                cnf_m = 1'b1;
                pc_m  = nxt;
            end else if (po) begin
                if (stk_m.size() > 0) begin
                    pc_m = stk_m.pop_back();
                end else begin
                    unf_m = 1'b1;
                    pc_m  = nxt;
                end
            end else if (pu) begin
                if (stk_m.size() < DEPTH) stk_m.push_back(nxt);
                else ovf_m = 1'b1;
                pc_m = ja;
            end else begin
                pc_m = si ? nxt : ja;
            end
        end
    endtask

    task automatic test_reset();
        step(1, 1, 1, 1, 0, 10'h155);
        step(1, 0, 0, 0, 1, 10'h0AA);
        checks++;
        if ({pc, sp, stack_empty, stack_full, overflow, underflow, conflict} !== {10'd0, 4'd0, 5'b10000}) begin
            errors++;
            $display("FAIL reset_state pc=%h sp=%0d e=%b f=%b o=%b u=%b c=%b want pc=0 sp=0 e=1 f=0 flags=0",
                     pc, sp, stack_empty, stack_full, overflow, underflow, conflict);
        end
    endtask

    task automatic test_sequential();
        for (int i = 1; i <= 5; i++) begin
            step(0, 1, 1, 0, 0, 10'($urandom));
            checks++;
            if (pc !== 10'(i) || sp !== 4'd0) begin
                errors++;
                $display("FAIL seq_step%0d pc=%h sp=%0d want pc=%h sp=0", i, pc, sp, 10'(i));
            end
        end
    endtask

    task automatic test_jump_stall();
        step(0, 1, 0, 0, 0, 10'h3A0);
        checks++;
        if (pc !== 10'h3A0) begin
            errors++;
            $display("FAIL jump pc=%h want 3a0", pc);
        end
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 1'($urandom), 1'($urandom), 1'($urandom), 10'($urandom));
            checks++;
            if (pc !== 10'h3A0 || sp !== 4'd0 || {overflow, underflow, conflict} !== 3'b000) begin
                errors++;
                $display("FAIL stall%0d pc=%h sp=%0d flags=%b want pc=3a0 sp=0 flags=000",
                         i, pc, sp, {overflow, underflow, conflict});
            end
        end
    endtask

    task automatic test_call_ret();
        logic [PC_W-1:0] exp_pc[5];
        logic [3:0]      exp_sp[5];
        exp_pc = '{10'h200, 10'h201, 10'h300, 10'h202, 10'h011};
        exp_sp = '{4'd1, 4'd1, 4'd2, 4'd1, 4'd0};
        step(1, 0, 1, 0, 0, 10'h0);
        step(0, 1, 0, 0, 0, 10'h010);
        step(0, 1, 0, 1, 0, 10'h200);
        for (int i = 0; i < 5; i++) begin
            if (i == 1) step(0, 1, 1, 0, 0, 10'h155);
            if (i == 2) step(0, 1, 0, 1, 0, 10'h300);
            if (i >= 3) step(0, 1, 1, 0, 1, 10'h0AA);
            checks++;
            if (pc !== exp_pc[i] || sp !== exp_sp[i]) begin
                errors++;
                $display("FAIL call_ret%0d pc=%h sp=%0d want pc=%h sp=%0d",
                         i, pc, sp, exp_pc[i], exp_sp[i]);
            end
        end
    endtask

    task automatic test_overflow();
        step(1, 0, 1, 0, 0, 10'h0);
        for (int i = 0; i < DEPTH; i++) begin
            step(0, 1, 1, 1, 0, 10'(10'h100 + 16 * i));
            checks++;
            if (sp !== 4'(i + 1) || pc !== 10'(10'h100 + 16 * i)) begin
                errors++;
                $display("FAIL call_fill%0d pc=%h sp=%0d want pc=%h sp=%0d",
                         i, pc, sp, 10'(10'h100 + 16 * i), i + 1);
            end
        end
        step(0, 1, 1, 1, 0, 10'h155);
        checks++;
        if (pc !== 10'h155 || sp !== 4'(DEPTH) || overflow !== 1'b1 || stack_full !== 1'b1) begin
            errors++;
            $display("FAIL overflow pc=%h sp=%0d ovf=%b full=%b want pc=155 sp=8 ovf=1 full=1",
                     pc, sp, overflow, stack_full);
        end
        // Top entry is the return address of the 8th CALL, made from pc 0x160.
        step(0, 1, 1, 0, 1, 10'h0);
        checks++;
        if (pc !== 10'h161 || sp !== 4'(DEPTH - 1) || stack_full !== 1'b0) begin
            errors++;
            $display("FAIL overflow_top pc=%h sp=%0d full=%b want pc=161 sp=7 full=0", pc, sp, stack_full);
        end
    endtask

    task automatic test_underflow_conflict();
        step(1, 0, 1, 0, 0, 10'h0);
        step(0, 1, 0, 0, 0, 10'h3FF);
        step(0, 1, 1, 0, 1, 10'h0);
        checks++;
        if (pc !== 10'h000 || underflow !== 1'b1 || sp !== 4'd0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL underflow pc=%h unf=%b sp=%0d ovf=%b want pc=000 unf=1 sp=0 ovf=0",
                     pc, underflow, sp, overflow);
        end
        step(0, 1, 0, 0, 0, 10'h3FF);
        step(0, 1, 0, 1, 0, 10'h050);
        step(0, 1, 1, 0, 1, 10'h0);
        checks++;
        if (pc !== 10'h000 || sp !== 4'd0) begin
            errors++;
            $display("FAIL call_wrap pc=%h sp=%0d want pc=000 sp=0", pc, sp);
        end
        step(0, 1, 0, 1, 0, 10'h080);
        step(0, 1, 0, 1, 1, 10'h123);
        checks++;
        if (pc !== 10'h081 || conflict !== 1'b1 || sp !== 4'd1) begin
            errors++;
            $display("FAIL conflict pc=%h cnf=%b sp=%0d want pc=081 cnf=1 sp=1", pc, conflict, sp);
        end
    endtask

    task automatic test_reset_mid_call();
        step(1, 0, 1, 0, 0, 10'h0);
        step(0, 1, 1, 0, 1, 10'h0);
        for (int i = 0; i < 3; i++) step(0, 1, 1, 1, 0, 10'(10'h040 + i));
        step(1, 1, 1, 1, 0, 10'h2AA);
        checks++;
        if ({pc, sp, overflow, underflow, conflict} !== {10'd0, 4'd0, 3'b000}) begin
            errors++;
            $display("FAIL reset_mid_call pc=%h sp=%0d flags=%b want pc=0 sp=0 flags=000",
                     pc, sp, {overflow, underflow, conflict});
        end
        step(0, 1, 1, 0, 1, 10'h0);
        checks++;
        if (underflow !== 1'b1 || pc !== 10'h001 || sp !== 4'd0) begin
            errors++;
            $display("FAIL post_reset_ret unf=%b pc=%h sp=%0d want unf=1 pc=001 sp=0", underflow, pc, sp);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(63) == 0), ($urandom_range(9) > 1), ($urandom_range(3) != 0),
                 ($urandom_range(4) == 0), ($urandom_range(4) == 0), 10'($urandom));
            checks++;
            if (pc !== pc_m || sp !== 4'(stk_m.size()) || stack_empty !== (stk_m.size() == 0)
                || stack_full !== (stk_m.size() == DEPTH)
                || {overflow, underflow, conflict} !== {ovf_m, unf_m, cnf_m}) begin
                errors++;
                $display("FAIL random%0d pc=%h sp=%0d flags=%b want pc=%h sp=%0d flags=%b",
                         i, pc, sp, {overflow, underflow, conflict}, pc_m, stk_m.size(),
                         {ovf_m, unf_m, cnf_m});
            end
        end
    endtask

    initial begin
        pc_m = '0; ovf_m = 1'b0; unf_m = 1'b0; cnf_m = 1'b0;
        test_reset();
        test_sequential();
        test_jump_stall();
        test_call_ret();
        test_overflow();
        test_underflow_conflict();
        test_reset_mid_call();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
